// File: rtl/regfile_dump_reader_pkg.sv
// Shared widths, FSM encoding and the captured-beat record for the register file dump reader.
package regfile_dump_reader_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } beat_t;

  // NUM_REGS is a power of two, so the natural ADDR_W-bit rollover is the modulo wrap.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive RF address range and streams {addr,data} beats: first beat 2 cycles after start,
// then 1 beat/cycle; a stalled beat holds all out_* stable until out_ready.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [ADDR_W-1:0] end_addr;
  beat_t             beat;
  logic              hs;

  assign hs       = out_valid & out_ready;
  assign out_addr = beat.addr;
  assign out_data = beat.data;
  assign out_last = beat.last;

  // rf_addr doubles as the cursor: once a beat is captured it already points at the next register,
  // so the following beat can be captured on the very edge the current one is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      end_addr  <= '0;
      rf_addr   <= '0;
      beat      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            end_addr <= last_addr;
            rf_addr  <= first_addr;
            busy     <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            beat      <= '{last: (rf_addr == end_addr), addr: rf_addr, data: rf_data};
            out_valid <= 1'b1;
            rf_addr   <= next_addr(rf_addr);
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (hs) begin
            if (beat.last) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else begin
              beat    <= '{last: (rf_addr == end_addr), addr: rf_addr, data: rf_data};
              rf_addr <= next_addr(rf_addr);
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
